// File: rtl/matmul_operand_reader.sv
//------------------------------------------------------------------------------
// matmul_operand_reader: fetches A, B and optional bias C from the scratchpad and
// streams them to the matmul calc block. Optional macro: SKIP_C_FETCH_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module matmul_operand_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  go_i,
   input  logic                  mode_i,
   input  logic [1:0]            n_dim_i,
   input  logic [1:0]            m_dim_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] address_o,
   input  logic [BUS_WIDTH-1:0]  rd_data_i,
   output logic [BUS_WIDTH-1:0]  data_a_o,
   output logic [BUS_WIDTH-1:0]  data_b_o,
   output logic [BUS_WIDTH-1:0]  data_c_o,
   output logic                  start_o,
   output logic                  mode_o,
   input  logic                  finish_mul_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int NELEM   = MAX_DIM * MAX_DIM;
   localparam int IAW     = 2 * $clog2(MAX_DIM);
   localparam int IDXW    = ($clog2(NELEM + 1) > 5) ? $clog2(NELEM + 1) : 5;

   localparam logic [4:0]      OPERAND_A = 5'b00100;
   localparam logic [4:0]      OPERAND_B = 5'b01000;
   localparam logic [4:0]      OPERAND_C = 5'b10000;
   localparam logic [IDXW-1:0] ONE       = IDXW'(1);
   localparam logic [IDXW-1:0] S_MAX     = IDXW'(NELEM);

   typedef enum logic [2:0] {
      IDLE, FETCH_A, FETCH_B, FETCH_C, DRAIN, STREAM, DONE
   } state_t;

   state_t               state_q, state_d;
   state_t               pend_st_q;
   logic [IDXW-1:0]      pend_idx_q;
   logic [1:0]           n_q, m_q;
   logic                 mode_q;
   logic [IDXW-1:0]      idx_q, idx_d, s_q, s_d;
   logic [IDXW-1:0]      n_ext, m_ext, c_elems;
   logic                 skip_c;
   logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
   logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
   logic [BUS_WIDTH-1:0] c_q [NELEM];

   assign n_ext   = IDXW'(n_q);
   assign m_ext   = IDXW'(m_q);
   assign c_elems = (n_ext + ONE) * (m_ext + ONE);
   assign mode_o  = mode_q;

`ifdef SKIP_C_FETCH_EN
   assign skip_c = ~mode_q;
`else
   assign skip_c = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      s_d       = s_q;
      rd_en_o   = 1'b0;
      address_o = '0;
      start_o   = 1'b0;
      done_o    = 1'b0;
      busy_o    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (go_i) begin
               state_d = FETCH_A;
               idx_d   = '0;
            end
         end
         FETCH_A: begin
            rd_en_o              = 1'b1;
            address_o[4:0]       = OPERAND_A;
            address_o[5 +: IAW]  = idx_q[IAW-1:0];
            if (idx_q == n_ext) begin
               idx_d   = '0;
               state_d = FETCH_B;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         FETCH_B: begin
            rd_en_o              = 1'b1;
            address_o[4:0]       = OPERAND_B;
            address_o[5 +: IAW]  = idx_q[IAW-1:0];
            if (idx_q == m_ext) begin
               idx_d   = '0;
               state_d = skip_c ? DRAIN : FETCH_C;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         FETCH_C: begin
            rd_en_o              = 1'b1;
            address_o[4:0]       = OPERAND_C;
            address_o[5 +: IAW]  = idx_q[IAW-1:0];
            if (idx_q == c_elems - ONE) begin
               idx_d   = '0;
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         DRAIN: begin
            s_d     = '0;
            state_d = STREAM;
         end
         STREAM: begin
            start_o = 1'b1;
            if (finish_mul_i)       state_d = DONE;
            else if (s_q != S_MAX)  s_d = s_q + ONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data lands one cycle after its strobe; the pending register names its slot.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_st_q  <= IDLE;
         pend_idx_q <= '0;
         idx_q      <= '0;
         s_q        <= '0;
         n_q        <= '0;
         m_q        <= '0;
         mode_q     <= 1'b0;
         for (int k = 0; k < MAX_DIM; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
         for (int k = 0; k < NELEM; k++) c_q[k] <= '0;
      end else begin
         idx_q      <= idx_d;
         s_q        <= s_d;
         pend_st_q  <= rd_en_o ? state_q : IDLE;
         pend_idx_q <= idx_q;
         if (state_q == IDLE && go_i) begin
            n_q    <= n_dim_i;
            m_q    <= m_dim_i;
            mode_q <= mode_i;
            for (int k = 0; k < MAX_DIM; k++) begin
               a_q[k] <= '0;
               b_q[k] <= '0;
            end
            for (int k = 0; k < NELEM; k++) c_q[k] <= '0;
         end
         for (int k = 0; k < MAX_DIM; k++) begin
            if (pend_st_q == FETCH_A && pend_idx_q == IDXW'(k)) a_q[k] <= rd_data_i;
            if (pend_st_q == FETCH_B && pend_idx_q == IDXW'(k)) b_q[k] <= rd_data_i;
         end
         for (int k = 0; k < NELEM; k++)
            if (pend_st_q == FETCH_C && pend_idx_q == IDXW'(k)) c_q[k] <= rd_data_i;
      end
   end

   always_comb begin
      data_a_o = '0;
      data_b_o = '0;
      data_c_o = '0;
      if (state_q == STREAM) begin
         for (int k = 0; k < MAX_DIM; k++) begin
            if (s_q == IDXW'(k) && s_q <= n_ext) data_a_o = a_q[k];
            if (s_q == IDXW'(k) && s_q <= m_ext) data_b_o = b_q[k];
         end
         for (int k = 0; k < NELEM; k++)
            if (s_q == IDXW'(k) && s_q < c_elems) data_c_o = c_q[k];
      end
   end

endmodule

`default_nettype wire

// File: doc/matmul_operand_reader.md
Name: matmul_operand_reader

Overview:
- Read-side front end of the matmul datapath.
- On a go pulse it fetches operands A, B and optionally bias C from the operand scratchpad over a single 1-cycle-latency read port, buffering them locally.
- It then streams them, one row/element per cycle, into the matmul calculation block's data_a/data_b/data_c inputs under a held start signal, and releases start once that block reports finish.
- It uses the same operand address encoding the calc block uses on its write side.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- BUS_WIDTH, 16, scratchpad data bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam).
- ADDR_WIDTH, 32, address bus width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- go_i  in  1  start request, sampled in IDLE only.
- mode_i  in  1  1 = accumulate onto bias C, 0 = no bias.
- n_dim_i  in  2  A rows minus 1.
- m_dim_i  in  2  B rows (C columns) minus 1.
- rd_en_o  out  1  scratchpad read strobe.
- address_o  out  ADDR_WIDTH  read address.
- rd_data_i  in  BUS_WIDTH  read data, valid the cycle after rd_en_o.
- data_a_o  out  BUS_WIDTH  A row to calc block.
- data_b_o  out  BUS_WIDTH  B row to calc block.
- data_c_o  out  BUS_WIDTH  C element to calc block.
- start_o  out  1  start to calc block, held high until finish.
- mode_o  out  1  registered copy of mode_i captured at go.
- finish_mul_i  in  1  finish from calc block.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
- Reset values: every output is 0, FSM is IDLE, buffers are cleared. Reset mid-operation aborts to IDLE next edge with start_o=0 and no done_o.
- Address encoding:
  - address_o[4:0]: OPERAND_A=5'b00100, OPERAND_B=5'b01000, OPERAND_C=5'b10000.
  - address_o[5+2*clog2(MAX_DIM)-1:5] = row or element index.
  - All other address bits are 0.
- FSM states: IDLE, FETCH_A, FETCH_B, FETCH_C, DRAIN, STREAM, DONE.
- IDLE:
  - On go_i=1, latch n_dim_i, m_dim_i and mode_i, then go to FETCH_A.
  - go_i in any other state is ignored.
- FETCH_A: rd_en_o=1 every cycle, index 0..n. After index n, go to FETCH_B.
- FETCH_B: index 0..m. After index m, go to FETCH_C (or to DRAIN if C is skipped).
- FETCH_C: index 0..(n+1)(m+1)-1, row-major. Then go to DRAIN.
- Reads are back-to-back with no bubbles. Total reads R = (n+1)+(m+1)+(n+1)(m+1).
- Read capture:
  - A pending-read register (type + index) captures rd_data_i one cycle after each strobe.
  - A row r goes to buffer slot r; B row r to slot r; C element e to slot e.
- DRAIN: one cycle for the last capture, rd_en_o=0, then STREAM.
- STREAM:
  - start_o=1, with a stream counter s starting at 0 in the first start_o cycle.
  - data_a_o = A[s] if s<=n, else 0.
  - data_b_o = B[s] if s<=m, else 0.
  - data_c_o = C[s] if s<(n+1)(m+1), else 0.
  - s saturates at MAX_DIM*MAX_DIM.
  - On the first cycle with finish_mul_i=1: start_o goes to 0 and data outputs go to 0 at the next edge, then DONE. A multi-cycle finish high is tolerated.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: go_i sampled at edge 0 → first rd_en_o in cycle 1 → start_o rises in cycle R+2.
- finish_mul_i outside STREAM is ignored.
- Unused buffer slots hold 0, so stale data from a previous run never appears on the data outputs.

Optional Feature:
- Macro: SKIP_C_FETCH_EN.
- Defined:
  - If the latched mode is 0, FETCH_C is skipped (FETCH_B → DRAIN) and data_c_o stays 0.
  - R = (n+1)+(m+1).
- Undefined:
  - C is always fetched regardless of mode.
  - mode_o still carries the latched mode.

Test Plan:
- Reset while in FETCH_B (n=1, m=1) → next edge IDLE; rd_en_o, start_o, busy_o, done_o all 0; no spurious done.
- go with n=1, m=1, mode=1, memory A0=0x0102, A1=0x0304, B0=0x0506, B1=0x0708, C0..C3=0x0010..0x0013:
  - 8 consecutive reads with addresses 0x04, 0x24, 0x08, 0x28, 0x10, 0x30, 0x50, 0x70.
  - start_o rises in cycle 10.
  - Stream cycles 0..3 present A0/A1, B0/B1, C0..C3, then zeros.
- go with n=0, m=1: A reads index 0 only, C reads 2 elements.
  - Stream: data_a_o=A0 at s=0, 0 at s≥1; data_c_o=C0, C1, then 0.
- In STREAM, finish_mul_i held high 3 cycles → start_o falls once; done_o pulses exactly once; busy_o drops with it.
- go_i pulsed during FETCH_A and STREAM → no restart and no extra reads; one done_o per accepted go.
- SKIP_C_FETCH_EN defined, mode=0, n=1, m=1 → exactly 4 reads (no OPERAND_C address); data_c_o=0 throughout; start_o in cycle 6.
